// File: rtl/core_hazard_pkg.sv
// core_hazard_pkg: shared constants, width helper and stall/flush priority for hazard units
package core_hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int X0         = 0;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_STALL,
        HZ_FLUSH
    } hz_action_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Flush always wins: a killed instruction must never hold the pipe.
    function automatic hz_action_e hz_resolve(input logic hazard, input logic flush);
        return flush ? HZ_FLUSH : (hazard ? HZ_STALL : HZ_NONE);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side hazard signals between core control and the hazard unit
interface hazard_scoreboard_if
    import core_hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_PEND = 4
);
    localparam int CW = clog2(MAX_PEND) + 1;

    logic              issue_valid_id;
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic              use_rs1_id;
    logic              use_rs2_id;
    logic [REG_AW-1:0] rd_id;
    logic              regwen_id;
    logic              memread_id;
    logic              mc_op_id;
    logic              mc_done;
    logic [REG_AW-1:0] mc_done_rd;
    logic              pcsrc_exe;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_exe;
    logic              flush_if;
    logic              flush_id;
    logic [CW-1:0]     pend_count;
    logic              pend_full;
    logic              err_sb;

    modport master (
        output issue_valid_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id,
               regwen_id, memread_id, mc_op_id, mc_done, mc_done_rd, pcsrc_exe,
        input  stall_if, stall_id, bubble_exe, flush_if, flush_id, pend_count,
               pend_full, err_sb
    );

    modport slave (
        input  issue_valid_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id,
               regwen_id, memread_id, mc_op_id, mc_done, mc_done_rd, pcsrc_exe,
        output stall_if, stall_id, bubble_exe, flush_if, flush_id, pend_count,
               pend_full, err_sb
    );

endinterface

// File: rtl/sb_fifo.sv
// sb_fifo: in-order FIFO of destination registers with parallel entry visibility
module sb_fifo
    import core_hazard_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [REG_AW-1:0]            push_rd_i,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0]            head_rd_o,
    output logic [clog2(DEPTH):0]        count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][REG_AW-1:0] mem_q, mem_d;
    logic                         do_push, do_pop;

    assign empty_o   = cnt_q == '0;
    assign full_o    = cnt_q == CW'(DEPTH);
    assign valid_o   = vld_q;
    assign rd_o      = mem_q;
    assign head_rd_o = mem_q[rptr_q];
    assign count_o   = cnt_q;

    // Next state; when full, a same-cycle push reuses the slot being popped, so set follows clear.
    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        vld_d   = vld_q;
        mem_d   = mem_q;
        if (do_pop) vld_d[rptr_q] = 1'b0;
        if (do_push) begin
            vld_d[wptr_q] = 1'b1;
            mem_d[wptr_q] = push_rd_i;
        end
        wptr_d = wptr_q + PW'(do_push);
        rptr_d = rptr_q + PW'(do_pop);
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
            mem_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/flush control with multi-cycle scoreboard, load-use window and branch flush
module hazard_scoreboard
    import core_hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_PEND = 4,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 2
) (
    input logic                clk,
    input logic                reset_n,
    hazard_scoreboard_if.slave hz
);
    localparam int LW = (LOAD_LAT > 0) ? clog2(LOAD_LAT + 1) : 1;
    localparam int FW = (BR_FLUSH > 1) ? clog2(BR_FLUSH) : 1;
    localparam logic [REG_AW-1:0] XZ = REG_AW'(X0);

    logic [MAX_PEND-1:0]             sb_vld;
    logic [MAX_PEND-1:0][REG_AW-1:0] sb_rd;
    logic [REG_AW-1:0]               head_rd;
    logic                            sb_empty, sb_full, push, issue, load_arm;
    logic                            flush_req, stall, flush;
    logic                            m_rs1, m_rs2, m_rd;
    logic                            raw_mc, waw_mc, full_mc, raw_ld, hazard;
    logic [LW-1:0]                   load_cnt_q, load_cnt_d;
    logic [REG_AW-1:0]               load_rd_q, load_rd_d;
    logic [FW-1:0]                   flush_cnt_q, flush_cnt_d;
    logic                            err_q, err_d;
    hz_action_e                      act;

    sb_fifo #(.DEPTH(MAX_PEND), .REG_AW(REG_AW)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (push),
        .pop_i     (hz.mc_done),
        .push_rd_i (hz.rd_id),
        .valid_o   (sb_vld),
        .rd_o      (sb_rd),
        .head_rd_o (head_rd),
        .count_o   (hz.pend_count),
        .full_o    (sb_full),
        .empty_o   (sb_empty)
    );

    // Compare ID registers against every live entry, including one retiring this cycle.
    always_comb begin
        m_rs1 = 1'b0;
        m_rs2 = 1'b0;
        m_rd  = 1'b0;
        for (int i = 0; i < MAX_PEND; i++) begin
            m_rs1 |= sb_vld[i] && sb_rd[i] == hz.rs1_id;
            m_rs2 |= sb_vld[i] && sb_rd[i] == hz.rs2_id;
            m_rd  |= sb_vld[i] && sb_rd[i] == hz.rd_id;
        end
        m_rs1 &= hz.rs1_id != XZ;
        m_rs2 &= hz.rs2_id != XZ;
        m_rd  &= hz.rd_id != XZ;
    end

    // Hazard detection and stall/flush resolution; outputs forced low while in reset.
    always_comb begin
        raw_mc    = hz.use_rs1_id & m_rs1 | hz.use_rs2_id & m_rs2;
        waw_mc    = hz.regwen_id & m_rd;
        full_mc   = hz.mc_op_id & sb_full & ~hz.mc_done;
        raw_ld    = (load_cnt_q != '0) & (hz.use_rs1_id & (hz.rs1_id == load_rd_q)
                                        | hz.use_rs2_id & (hz.rs2_id == load_rd_q));
        hazard    = hz.issue_valid_id & (raw_mc | waw_mc | full_mc | raw_ld);
        flush_req = hz.pcsrc_exe | (flush_cnt_q != '0);
        act       = reset_n ? hz_resolve(hazard, flush_req) : HZ_NONE;
        stall     = act == HZ_STALL;
        flush     = act == HZ_FLUSH;
        issue     = hz.issue_valid_id & ~stall & ~flush;
        push      = issue & hz.mc_op_id & hz.regwen_id & (hz.rd_id != XZ);
        load_arm  = issue & hz.memread_id & hz.regwen_id & (hz.rd_id != XZ);
    end

    assign hz.stall_if   = stall;
    assign hz.stall_id   = stall;
    assign hz.bubble_exe = stall;
    assign hz.flush_if   = flush;
    assign hz.flush_id   = flush;
    assign hz.pend_full  = sb_full;
    assign hz.err_sb     = err_q;

    // Counter next state: load window and flush window count down every cycle regardless of stall.
    always_comb begin
        load_cnt_d  = load_arm ? LW'(LOAD_LAT)
                    : (load_cnt_q != '0) ? load_cnt_q - LW'(1) : load_cnt_q;
        load_rd_d   = load_arm ? hz.rd_id : load_rd_q;
        flush_cnt_d = hz.pcsrc_exe ? FW'(BR_FLUSH - 1)
                    : (flush_cnt_q != '0) ? flush_cnt_q - FW'(1) : flush_cnt_q;
        err_d       = err_q | hz.mc_done & (sb_empty | (hz.mc_done_rd != head_rd));
    end

    // Load window, flush window and sticky protocol error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt_q  <= '0;
            load_rd_q   <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            load_rd_q   <= load_rd_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with a queued expectation per cycle, checked by a negedge monitor
module tb_hazard_scoreboard;
    import core_hazard_pkg::*;

    localparam int AW = 5;
    localparam int MP = 4;
    localparam int LL = 1;
    localparam int BF = 3;

    typedef struct {
        string      name;
        logic       stall;
        logic       flush;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    hazard_scoreboard_if #(.REG_AW(AW), .MAX_PEND(MP)) hz();

    hazard_scoreboard #(.REG_AW(AW), .MAX_PEND(MP), .LOAD_LAT(LL), .BR_FLUSH(BF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared mid-cycle once inputs have settled.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({hz.stall_if, hz.stall_id, hz.bubble_exe, hz.flush_if, hz.flush_id,
                 hz.pend_count, hz.pend_full, hz.err_sb}
                !== {{3{e.stall}}, {2{e.flush}}, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL %s: got stall_if=%b stall_id=%b bubble=%b flush_if=%b flush_id=%b cnt=%0d full=%b err=%b; expected stall=%b flush=%b cnt=%0d full=%b err=%b",
                         e.name, hz.stall_if, hz.stall_id, hz.bubble_exe, hz.flush_if, hz.flush_id,
                         hz.pend_count, hz.pend_full, hz.err_sb,
                         e.stall, e.flush, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    end

    task automatic clr();
        hz.issue_valid_id = 1'b0;
        hz.rs1_id         = '0;
        hz.rs2_id         = '0;
        hz.use_rs1_id     = 1'b0;
        hz.use_rs2_id     = 1'b0;
        hz.rd_id          = '0;
        hz.regwen_id      = 1'b0;
        hz.memread_id     = 1'b0;
        hz.mc_op_id       = 1'b0;
        hz.mc_done        = 1'b0;
        hz.mc_done_rd     = '0;
        hz.pcsrc_exe      = 1'b0;
    endtask

    task automatic ins(input int r1, input logic u1, input int r2, input logic u2,
                       input int rd, input logic ld, input logic mc);
        hz.issue_valid_id = 1'b1;
        hz.rs1_id         = AW'(r1);
        hz.use_rs1_id     = u1;
        hz.rs2_id         = AW'(r2);
        hz.use_rs2_id     = u2;
        hz.rd_id          = AW'(rd);
        hz.regwen_id      = 1'b1;
        hz.memread_id     = ld;
        hz.mc_op_id       = mc;
    endtask

    task automatic done(input int rd);
        hz.mc_done    = 1'b1;
        hz.mc_done_rd = AW'(rd);
    endtask

    // Queue this cycle's expectation, then move to the next cycle with inputs cleared.
    task automatic cyc(input string n, input logic s, input logic f, input int c, input logic er);
        exp_t x;
        x.name  = n;
        x.stall = s;
        x.flush = f;
        x.cnt   = 3'(c);
        x.err   = er;
        q.push_back(x);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        // load-use
        ins(1, 1, 0, 0, 5, 1, 0);             cyc("load_x5", 0, 0, 0, 0);
        ins(5, 1, 1, 1, 6, 0, 0);             cyc("ld_use_stall", 1, 0, 0, 0);
        ins(5, 1, 1, 1, 6, 0, 0);             cyc("ld_use_release", 0, 0, 0, 0);
        // multi-cycle RAW held through the pop cycle
        ins(2, 1, 3, 1, 7, 0, 1);             cyc("div_x7", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            ins(7, 1, 0, 0, 8, 0, 0);         cyc("mc_raw_wait", 1, 0, 1, 0);
        end
        ins(7, 1, 0, 0, 8, 0, 0); done(7);    cyc("mc_raw_pop", 1, 0, 1, 0);
        ins(7, 1, 0, 0, 8, 0, 0);             cyc("mc_raw_release", 0, 0, 0, 0);
        // fill scoreboard
        for (int k = 1; k <= 4; k++) begin
            ins(0, 0, 0, 0, k, 0, 1);         cyc("mc_fill", 0, 0, k - 1, 0);
        end
        ins(0, 0, 0, 0, 9, 0, 1);             cyc("full_stall", 1, 0, 4, 0);
        ins(0, 0, 0, 0, 9, 0, 1); done(1);    cyc("full_push_pop", 0, 0, 4, 0);
        ins(0, 0, 0, 0, 3, 0, 0);             cyc("waw_stall", 1, 0, 4, 0);
        done(2);                              cyc("drain_x2", 0, 0, 4, 0);
        done(3);                              cyc("drain_x3", 0, 0, 3, 0);
        done(4);                              cyc("drain_x4", 0, 0, 2, 0);
        done(9);                              cyc("drain_x9", 0, 0, 1, 0);
        cyc("drained", 0, 0, 0, 0);
        // branch flush over a load-use hazard, with reload
        ins(1, 1, 0, 0, 5, 1, 0);             cyc("load_x5_b", 0, 0, 0, 0);
        ins(5, 1, 0, 0, 6, 1, 0); hz.pcsrc_exe = 1'b1;
                                              cyc("flush_over_stall", 0, 1, 0, 0);
        ins(0, 0, 0, 0, 11, 0, 1);            cyc("flush_mc_killed", 0, 1, 0, 0);
        ins(11, 1, 0, 0, 12, 0, 0); hz.pcsrc_exe = 1'b1;
                                              cyc("flush_reload", 0, 1, 0, 0);
        ins(11, 1, 0, 0, 12, 0, 0);           cyc("flush_tail1", 0, 1, 0, 0);
        ins(11, 1, 0, 0, 12, 0, 0);           cyc("flush_tail2", 0, 1, 0, 0);
        ins(11, 1, 0, 0, 12, 0, 0);           cyc("flush_end", 0, 0, 0, 0);
        // pop on empty FIFO
        done(3);                              cyc("done_empty", 0, 0, 0, 0);
        cyc("err_sticky", 0, 0, 0, 1);
        // async reset with pending entries and active flush window
        ins(0, 0, 0, 0, 1, 0, 1);             cyc("pend1", 0, 0, 0, 1);
        ins(0, 0, 0, 0, 2, 0, 1);             cyc("pend2", 0, 0, 1, 1);
        ins(0, 0, 0, 0, 3, 0, 1);             cyc("pend3", 0, 0, 2, 1);
        hz.pcsrc_exe = 1'b1;                  cyc("flush_pending", 0, 1, 3, 1);
        reset_n = 1'b0;
        ins(1, 1, 0, 0, 4, 0, 0);             cyc("async_reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        ins(1, 1, 0, 0, 4, 0, 0);             cyc("post_reset", 0, 0, 0, 0);
        // head mismatch
        ins(0, 0, 0, 0, 4, 0, 1);             cyc("mc_x4", 0, 0, 0, 0);
        done(5);                              cyc("done_mismatch", 0, 0, 1, 0);
        cyc("err_mismatch", 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
